// File: rtl/act_lut_scheduler_pkg.sv
// rtl/act_lut_scheduler_pkg.sv - shared widths, state encoding and saturation bounds for the activation LUT scheduler
package act_lut_scheduler_pkg;

    localparam int DEF_DW = 8;
    localparam int DEF_AW = 4;
    localparam int DEF_FW = DEF_DW - DEF_AW;

    // Output clamp range of a signed DEF_DW-bit activation
    localparam int SAT_MAX = (1 << (DEF_DW - 1)) - 1;
    localparam int SAT_MIN = -(1 << (DEF_DW - 1));

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOOK = 2'd1,
        CALC = 2'd2,
        RESP = 2'd3
    } state_t;

endpackage

// File: rtl/act_rr_arbiter.sv
// rtl/act_rr_arbiter.sv - combinational round-robin pick of the first requester at or above ptr
module act_rr_arbiter #(
    parameter int N_REQ = 4,
    parameter int IDW   = $clog2(N_REQ)
) (
    input  logic [N_REQ-1:0] req,
    input  logic [IDW-1:0]   ptr,
    output logic [IDW-1:0]   grant,
    output logic             any_req
);

    // Scan ptr, ptr+1, ... wrapping at N_REQ; the first set request wins
    always_comb begin
        int idx;
        idx     = 0;
        grant   = '0;
        any_req = 1'b0;
        for (int k = 0; k < N_REQ; k++) begin
            idx = int'(ptr) + k;
            if (idx >= N_REQ) begin
                idx = idx - N_REQ;
            end
            if (!any_req && req[IDW'(idx)]) begin
                any_req = 1'b1;
                grant   = IDW'(idx);
            end
        end
    end

endmodule

// File: rtl/act_lut_scheduler.sv
// rtl/act_lut_scheduler.sv - time-shares one activation LUT among N_REQ neurons with linear interpolation
module act_lut_scheduler
    import act_lut_scheduler_pkg::*;
#(
    parameter int N_REQ = 4,
    parameter int DW    = DEF_DW,
    parameter int AW    = DEF_AW,
    parameter int IDW   = $clog2(N_REQ)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [N_REQ-1:0]   req,
    input  logic [N_REQ*DW-1:0] z_in,
    output logic [AW-1:0]      lut_addr,
    input  logic [DW-1:0]      lut_base,
    input  logic [DW-1:0]      lut_next,
    output logic [N_REQ-1:0]   ack,
    output logic [DW-1:0]      y_out,
    output logic [IDW-1:0]     y_id,
    output logic               busy
);

    localparam int FW = DW - AW;
    // Wide enough for (next-base) * frac plus base without overflow
    localparam int PW = DW + FW + 1;
    localparam logic signed [PW-1:0] Y_MAX   = PW'(SAT_MAX);
    localparam logic signed [PW-1:0] Y_MIN   = PW'(SAT_MIN);
    // Top positive segment: interpolating towards entry 8 would cross the sign boundary
    localparam logic [AW-1:0]        TOP_POS = AW'((1 << (AW - 1)) - 1);
    localparam logic [IDW-1:0]       LAST_ID = IDW'(N_REQ - 1);

    state_t state, state_nx;

    logic [IDW-1:0]          ptr;
    logic [IDW-1:0]          id;
    logic [IDW-1:0]          grant;
    logic                    any_req;
    logic [DW-1:0]           z_win;
    logic [FW-1:0]           frac_q;
    logic signed [DW-1:0]    base_q;
    logic signed [DW-1:0]    next_q;
    logic signed [PW-1:0]    diff_x;
    logic signed [PW-1:0]    frac_x;
    logic signed [PW-1:0]    prod;
    logic signed [PW-1:0]    y_sum;
    logic [DW-1:0]           y_sat;

    act_rr_arbiter #(
        .N_REQ (N_REQ),
        .IDW   (IDW)
    ) u_arb (
        .req     (req),
        .ptr     (ptr),
        .grant   (grant),
        .any_req (any_req)
    );

    assign z_win = z_in[int'(grant)*DW +: DW];

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    // Fixed four-cycle service; only IDLE looks at the requests
    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (any_req) state_nx = LOOK;
            LOOK:    state_nx = CALC;
            CALC:    state_nx = RESP;
            RESP:    state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    // Ack pulses only in RESP for the served neuron; busy whenever a service is in flight
    always_comb begin
        ack = '0;
        if (state == RESP) begin
            ack[id] = 1'b1;
        end
        busy = (state != IDLE);
    end

    // Interpolate base..next by frac/2^FW with floor, then clamp and saturate
    always_comb begin
        diff_x = PW'(next_q) - PW'(base_q);
        frac_x = PW'(frac_q);
        prod   = diff_x * frac_x;
        y_sum  = PW'(base_q) + (prod >>> FW);
        if (lut_addr == TOP_POS) begin
            y_sat = base_q;
        end else if (y_sum > Y_MAX) begin
            y_sat = Y_MAX[DW-1:0];
        end else if (y_sum < Y_MIN) begin
            y_sat = Y_MIN[DW-1:0];
        end else begin
            y_sat = y_sum[DW-1:0];
        end
    end

    // Datapath: capture winner, sample LUT, register result, advance rr pointer
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ptr      <= '0;
            id       <= '0;
            lut_addr <= '0;
            frac_q   <= '0;
            base_q   <= '0;
            next_q   <= '0;
            y_out    <= '0;
            y_id     <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (any_req) begin
                        id       <= grant;
                        lut_addr <= z_win[DW-1:FW];
                        frac_q   <= z_win[FW-1:0];
                    end
                end
                LOOK: begin
                    base_q <= lut_base;
                    next_q <= lut_next;
                end
                CALC: begin
                    y_out <= y_sat;
                    y_id  <= id;
                end
                RESP: begin
                    ptr <= (id == LAST_ID) ? '0 : id + 1'b1;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_act_lut_scheduler.sv
// tb/tb_act_lut_scheduler.sv - randomized and directed self-checking bench for act_lut_scheduler
module tb_act_lut_scheduler;

    localparam int N = 4;

    logic           clk = 1'b0;
    logic           rst = 1'b1;
    logic [N-1:0]   req = '0;
    logic [N*8-1:0] z_in = '0;
    logic [3:0]     lut_addr;
    logic [7:0]     lut_base;
    logic [7:0]     lut_next;
    logic [N-1:0]   ack;
    logic [7:0]     y_out;
    logic [1:0]     y_id;
    logic           busy;

    logic signed [7:0] lut [16];

    int checks = 0;
    int errors = 0;

    typedef struct { int id; int y; int c; } ev_t;
    ev_t log_q[$];

    // reference state: cycle count, last grant cycle, served id, expected outputs
    int   cyc     = 0;
    int   m_gc    = -100;
    int   m_id    = 0;
    int   m_ptr   = 0;
    int   m_addr  = 0;
    int   m_ypend = 0;
    int   m_yout  = 0;
    int   m_yid   = 0;
    bit   found;
    logic [N-1:0] ea;
    logic [7:0]   zz;
    int   exp_rr [4] = '{13, 15, -6, -15};

    always #5 clk = ~clk;

    assign lut_base = lut[lut_addr];
    assign lut_next = lut[lut_addr + 4'd1];

    act_lut_scheduler #(.N_REQ(N)) dut (
        .clk      (clk),
        .rst      (rst),
        .req      (req),
        .z_in     (z_in),
        .lut_addr (lut_addr),
        .lut_base (lut_base),
        .lut_next (lut_next),
        .ack      (ack),
        .y_out    (y_out),
        .y_id     (y_id),
        .busy     (busy)
    );

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            if (errors <= 40) $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    function automatic int ref_y(input int a, input int f);
        int b  = lut[a];
        int nx = lut[(a + 1) % 16];
        int d;
        int q;
        int y;
        if (a == 7) return b;
        d = (nx - b) * f;
        q = (d >= 0) ? d / 16 : -((-d + 15) / 16);
        y = b + q;
        if (y > 127) y = 127;
        if (y < -128) y = -128;
        return y;
    endfunction

    // Reference: a request seen while free starts a 4-cycle slot; result appears in slot cycle 3
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            cyc = 0; m_gc = -100; m_ptr = 0; m_addr = 0; m_yout = 0; m_yid = 0;
        end else begin
            if (cyc == m_gc + 2) begin
                m_yout = m_ypend;
                m_yid  = m_id;
            end
            if (cyc >= m_gc + 4 && req != 0) begin
                found = 0;
                for (int k = 0; k < N; k++) begin
                    if (!found && req[(m_ptr + k) % N]) begin
                        found = 1;
                        m_id  = (m_ptr + k) % N;
                    end
                end
                m_gc    = cyc;
                m_addr  = int'(z_in[m_id*8+4 +: 4]);
                m_ypend = ref_y(m_addr, int'(z_in[m_id*8 +: 4]));
                m_ptr   = (m_id + 1) % N;
            end
            cyc++;
        end
    end

    // Compare every cycle and log each served result
    always @(negedge clk) begin
        ea = '0;
        if (!rst && cyc == m_gc + 3) ea[m_id] = 1'b1;
        chk("ack", int'(ack), int'(ea));
        chk("busy", int'(busy), int'(!rst && cyc >= m_gc + 1 && cyc <= m_gc + 3));
        chk("lut_addr", int'(lut_addr), m_addr);
        chk("y_out", int'($signed(y_out)), m_yout);
        chk("y_id", int'(y_id), m_yid);
        if (ack != 0) log_q.push_back('{int'(y_id), int'($signed(y_out)), cyc});
    end

    task automatic tick();
        @(negedge clk);
        #1;
        for (int i = 0; i < N; i++) if (ack[i]) req[i] = 1'b0;
    endtask

    task automatic wait_log(input int n, input int budget);
        int k = 0;
        while (log_q.size() < n && k < budget) begin
            tick();
            k++;
        end
        chk("ack_arrived", int'(log_q.size() >= n), 1);
    endtask

    task automatic serve(input int i, input logic [7:0] z, input int exp_y, input string nm);
        int c0;
        tick();
        log_q.delete();
        z_in[i*8 +: 8] = z;
        req[i] = 1'b1;
        c0 = cyc;
        wait_log(1, 20);
        chk({nm, "_id"}, log_q[0].id, i);
        chk({nm, "_y"}, log_q[0].y, exp_y);
        chk({nm, "_latency"}, log_q[0].c - c0, 3);
    endtask

    task automatic drain();
        int k = 0;
        while ((req != 0 || busy) && k < 100) begin
            tick();
            k++;
        end
        chk("drain", int'(req == 0 && !busy), 1);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: bench did not finish, checks %0d", checks);
        $fatal(1, "watchdog");
    end

    initial begin
        lut = '{0, 12, 15, 15, 15, 15, 15, 15, -15, -15, -15, -15, -15, -15, -14, -12};
        chk("model_pin_interp", ref_y(1, 8), 13);
        chk("model_pin_wrap", ref_y(15, 8), -6);
        chk("model_pin_clamp", ref_y(7, 15), 15);

        // All four requesting out of reset: served 0,1,2,3 at cycles 3,7,11,15
        z_in = {8'h88, 8'hF8, 8'h7F, 8'h18};
        req  = 4'hF;
        repeat (2) @(negedge clk);
        chk("reset_busy", int'(busy), 0);
        chk("reset_y_out", int'(y_out), 0);
        rst = 1'b0;
        wait_log(4, 60);
        for (int k = 0; k < 4; k++) begin
            chk("rr_id", log_q[k].id, k);
            chk("rr_cycle", log_q[k].c, 3 + 4*k);
            chk("rr_y", log_q[k].y, exp_rr[k]);
        end

        // Re-raise 0 and 2 (ptr=0): 0 then 2; then again with ptr=3: 0 first
        for (int r = 0; r < 2; r++) begin
            log_q.delete();
            z_in[0 +: 8]  = (r == 0) ? 8'h70 : 8'h18;
            z_in[16 +: 8] = (r == 0) ? 8'h88 : 8'hF8;
            req[0] = 1'b1;
            req[2] = 1'b1;
            wait_log(2, 40);
            chk("rr2_first", log_q[0].id, 0);
            chk("rr2_second", log_q[1].id, 2);
            chk("rr2_y0", log_q[0].y, (r == 0) ? 15 : 13);
            chk("rr2_y2", log_q[1].y, (r == 0) ? -15 : -6);
        end

        serve(0, 8'h18, 13, "single");
        serve(3, 8'hF8, -6, "wrap");
        serve(2, 8'h88, -15, "neg");
        serve(1, 8'h7F, 15, "clamp7f");
        serve(0, 8'h70, 15, "clamp70");

        tick();
        lut[3] = 8'sd10;
        lut[4] = -8'sd10;
        serve(1, 8'h35, 3, "floor");
        tick();
        lut[5] = 8'sd127;
        lut[6] = 8'sd127;
        serve(2, 8'h5A, 127, "sat");

        // Reset during CALC: outputs drop at once, no ack; pending 1,2 served from ptr=0
        tick();
        lut = '{0, 12, 15, 15, 15, 15, 15, 15, -15, -15, -15, -15, -15, -15, -14, -12};
        log_q.delete();
        z_in[8 +: 8]  = 8'h18;
        z_in[16 +: 8] = 8'hF8;
        req[1] = 1'b1;
        req[2] = 1'b1;
        tick();
        tick();
        chk("calc_busy", int'(busy), 1);
        rst = 1'b1;
        #1;
        chk("rst_ack", int'(ack), 0);
        chk("rst_busy", int'(busy), 0);
        chk("rst_y_out", int'(y_out), 0);
        chk("rst_lut_addr", int'(lut_addr), 0);
        @(negedge clk);
        @(negedge clk);
        chk("rst_no_ack", log_q.size(), 0);
        rst = 1'b0;
        wait_log(2, 40);
        chk("rst_first", log_q[0].id, 1);
        chk("rst_second", log_q[1].id, 2);
        chk("rst_y1", log_q[0].y, 13);
        chk("rst_y2", log_q[1].y, -6);

        // Random traffic over two random LUT images
        for (int round = 0; round < 2; round++) begin
            drain();
            for (int a = 0; a < 16; a++) lut[a] = 8'($urandom);
            repeat (700) begin
                tick();
                for (int i = 0; i < N; i++) begin
                    if (!req[i] && !ack[i] && $urandom_range(0, 2) == 0) begin
                        zz = 8'($urandom);
                        if ($urandom_range(0, 7) == 0) zz[7:4] = 4'h7;
                        else if ($urandom_range(0, 7) == 0) zz[7:4] = 4'hF;
                        z_in[i*8 +: 8] = zz;
                        req[i] = 1'b1;
                    end
                end
            end
        end
        drain();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
